// File: rtl/vreg_addr_seq_if.sv
// Request and beat-stream bundle of the vector-register address sequencer.
// The slave side is the sequencer; the master side is the requester plus beat consumer.
interface vreg_addr_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8
);
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [2:0]            req_max_reg;
  logic [OFF_WIDTH-1:0]  req_max_off;
  logic [OFF_WIDTH-1:0]  req_start_off;
  logic [1:0]            req_mode;
  logic [1:0]            req_sew;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [OFF_WIDTH-1:0]  out_off;
  logic                  out_turn;
  logic                  out_first;
  logic                  out_last;
  logic                  err;

  modport slave (
    input  flush, req_valid, req_base, req_max_reg, req_max_off, req_start_off,
           req_mode, req_sew, out_ready,
    output req_ready, out_valid, out_addr, out_off, out_turn, out_first, out_last, err
  );

  modport master (
    output flush, req_valid, req_base, req_max_reg, req_max_off, req_start_off,
           req_mode, req_sew, out_ready,
    input  req_ready, out_valid, out_addr, out_off, out_turn, out_first, out_last, err
  );
endinterface

// File: rtl/vreg_addr_seq.sv
// Vector-register address sequencer: one register-group request in, registered
// (addr, offset) beat stream out. VREG_ADDR_SEQ_WIDEN_EN enables double-beat widening.
module vreg_addr_seq #(
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  vreg_addr_seq_if.slave     bus
);
  localparam int                   BEATS         = VLEN / DATA_WIDTH;
  localparam logic [OFF_WIDTH-1:0] WHOLE_MAX_OFF = OFF_WIDTH'(BEATS - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [2:0]            max_reg_q, max_reg_d, reg_q, reg_d;
  logic [OFF_WIDTH-1:0]  max_off_q, max_off_d, off_q, off_d;
  logic                  vld_q, vld_d, first_q, first_d, last_q, last_d, err_q, err_d;

  logic                  fire, accept;
  logic [2:0]            req_mreg;
  logic [OFF_WIDTH-1:0]  req_moff;
  logic [2:0]            nreg;
  logic [OFF_WIDTH-1:0]  noff;
  logic                  nturn;

`ifdef VREG_ADDR_SEQ_WIDEN_EN
  logic widen_q, widen_d, turn_q, turn_d, req_widen;
  assign req_widen = (bus.req_mode == 2'b01);
`else
  localparam logic widen_q   = 1'b0;
  localparam logic turn_q    = 1'b0;
  localparam logic req_widen = 1'b0;
`endif

  assign fire          = vld_q & bus.out_ready;
  // Chaining: a new request may land on the same edge the last beat leaves.
  assign bus.req_ready = ~bus.flush & ((state_q == IDLE) | (fire & last_q));
  assign accept        = bus.req_valid & bus.req_ready;

  // Effective limits of the incoming request; whole-register mode overrides them.
  always_comb begin
    req_mreg = bus.req_max_reg;
    req_moff = bus.req_max_off;
    if (bus.req_mode == 2'b10) begin
      req_mreg = 3'((4'd1 << bus.req_sew) - 4'd1);
      req_moff = WHOLE_MAX_OFF;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    max_reg_d = max_reg_q;
    max_off_d = max_off_q;
    reg_d     = reg_q;
    off_d     = off_q;
    vld_d     = vld_q;
    first_d   = first_q;
    last_d    = last_q;
    err_d     = 1'b0;
`ifdef VREG_ADDR_SEQ_WIDEN_EN
    turn_d    = turn_q;
    widen_d   = widen_q;
`endif

    // Successor of the current beat within the latched sequence.
    nreg  = reg_q;
    noff  = off_q;
    nturn = 1'b0;
    if (widen_q && !turn_q) begin
      nturn = 1'b1;
    end else if (off_q == max_off_q) begin
      noff = '0;
      nreg = reg_q + 3'd1;
    end else begin
      noff = off_q + OFF_WIDTH'(1);
    end

    if (bus.flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else if (accept) begin
      base_d    = bus.req_base;
      max_reg_d = req_mreg;
      max_off_d = req_moff;
      reg_d     = '0;
      off_d     = bus.req_start_off;
`ifdef VREG_ADDR_SEQ_WIDEN_EN
      widen_d   = req_widen;
      turn_d    = 1'b0;
`endif
      if (bus.req_start_off > req_moff) begin
        // Empty stream: nothing to emit, flag it and fall back to IDLE.
        state_d = IDLE;
        vld_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        state_d = RUN;
        vld_d   = 1'b1;
        first_d = 1'b1;
        last_d  = (req_mreg == 3'd0) && (bus.req_start_off == req_moff) && !req_widen;
      end
    end else if (fire) begin
      if (last_q) begin
        state_d = IDLE;
        vld_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        reg_d   = nreg;
        off_d   = noff;
`ifdef VREG_ADDR_SEQ_WIDEN_EN
        turn_d  = nturn;
`endif
        first_d = 1'b0;
        last_d  = (nreg == max_reg_q) && (noff == max_off_q) && (!widen_q || nturn);
      end
    end

    addr_d = base_d + ADDR_WIDTH'(reg_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      max_reg_q <= '0;
      max_off_q <= '0;
      reg_q     <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      max_reg_q <= max_reg_d;
      max_off_q <= max_off_d;
      reg_q     <= reg_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

`ifdef VREG_ADDR_SEQ_WIDEN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      turn_q  <= 1'b0;
      widen_q <= 1'b0;
    end else begin
      turn_q  <= turn_d;
      widen_q <= widen_d;
    end
  end
`endif

  assign bus.out_valid = vld_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_off   = off_q;
  assign bus.out_turn  = turn_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_vreg_addr_seq.sv
// Bench for vreg_addr_seq: request table plus hand sequences, with a beat
// scoreboard filled from an independent model at each accepted request.
module tb_vreg_addr_seq;
`ifdef VREG_ADDR_SEQ_WIDEN_EN
  localparam bit WIDEN = 1'b1;
`else
  localparam bit WIDEN = 1'b0;
`endif
  localparam int WB = WIDEN ? 4 : 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vreg_addr_seq_if #(.ADDR_WIDTH(5), .OFF_WIDTH(8)) bus ();

  vreg_addr_seq #(.VLEN(16384), .DATA_WIDTH(64), .ADDR_WIDTH(5), .OFF_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] off;
    logic       turn;
    logic       first;
    logic       last;
  } beat_t;

  typedef struct {
    logic [4:0] base;
    logic [2:0] mreg;
    logic [7:0] moff;
    logic [7:0] st;
    logic [1:0] mode;
    logic [1:0] sew;
    int         rdy;
    int         beats;
    int         errs;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[9];
  int    total = 0, bad = 0;
  int    nbeats, nerrs;
  bit    err_due, accepted, prev_stall;
  beat_t prev_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expand one request into its expected beats.
  task automatic push_req(input logic [4:0] base, input logic [2:0] mreg_in,
                          input logic [7:0] moff_in, input logic [7:0] st,
                          input logic [1:0] mode, input logic [1:0] sew);
    int mreg, moff, w, tot, k, s;
    beat_t b;
    mreg = (mode == 2'b10) ? (1 << sew) - 1 : int'(mreg_in);
    moff = (mode == 2'b10) ? 255 : int'(moff_in);
    w    = (WIDEN && mode == 2'b01) ? 2 : 1;
    if (int'(st) > moff) begin
      err_due = 1'b1;
      return;
    end
    tot = ((mreg + 1) * (moff + 1) - int'(st)) * w;
    k = 0;
    for (int r = 0; r <= mreg; r++) begin
      s = (r == 0) ? int'(st) : 0;
      for (int o = s; o <= moff; o++)
        for (int t = 0; t < w; t++) begin
          b.addr  = 5'(int'(base) + r);
          b.off   = 8'(o);
          b.turn  = t[0];
          b.first = (k == 0);
          b.last  = (k == tot - 1);
          sb.push_back(b);
          k++;
        end
    end
  endtask

  function automatic beat_t cur_out();
    beat_t b;
    b.addr  = bus.out_addr;
    b.off   = bus.out_off;
    b.turn  = bus.out_turn;
    b.first = bus.out_first;
    b.last  = bus.out_last;
    return b;
  endfunction

  // Called at a negedge with inputs already driven; checks, models the coming edge.
  task automatic step();
    logic exp_ready;
    beat_t b;
    #1;
    accepted = 1'b0;
    b = cur_out();
    chk("err", bus.err, err_due);
    if (bus.err) nerrs++;
    err_due = 1'b0;
    chk("out_valid", bus.out_valid, sb.size() > 0);
    if (prev_stall) chk("stall_hold", b, prev_out);
    if (bus.out_valid && sb.size() > 0) chk("beat", b, sb[0]);
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      exp_ready = !bus.flush && (sb.size() == 0 || (sb.size() == 1 && bus.out_ready));
      chk("req_ready", bus.req_ready, exp_ready);
      prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_out   = b;
      if (bus.flush) begin
        sb.delete();
      end else if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        nbeats++;
      end
      if (bus.req_valid && bus.req_ready && !bus.flush) begin
        accepted = 1'b1;
        push_req(bus.req_base, bus.req_max_reg, bus.req_max_off, bus.req_start_off,
                 bus.req_mode, bus.req_sew);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input logic [4:0] base, input logic [2:0] mreg, input logic [7:0] moff,
                         input logic [7:0] st, input logic [1:0] mode, input logic [1:0] sew);
    bus.req_base = base; bus.req_max_reg = mreg; bus.req_max_off = moff;
    bus.req_start_off = st; bus.req_mode = mode; bus.req_sew = sew;
  endtask

  task automatic run_vec(input int i);
    bit done_acc;
    int c;
    set_req(vecs[i].base, vecs[i].mreg, vecs[i].moff, vecs[i].st, vecs[i].mode, vecs[i].sew);
    bus.req_valid = 1'b1;
    nbeats = 0; nerrs = 0; done_acc = 1'b0;
    for (c = 0; c < 3000; c++) begin
      case (vecs[i].rdy)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (c % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      if (accepted) begin
        done_acc = 1'b1;
        bus.req_valid = 1'b0;
      end
      if (done_acc && sb.size() == 0 && !err_due) break;
    end
    chk($sformatf("vec%0d_timeout", i), c < 3000, 1);
    chk($sformatf("vec%0d_beats", i), nbeats, vecs[i].beats);
    chk($sformatf("vec%0d_errs", i), nerrs, vecs[i].errs);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, bus.out_valid, 0);
    chk({nm, "_addr"},  bus.out_addr, 0);
    chk({nm, "_off"},   bus.out_off, 0);
    chk({nm, "_turn"},  bus.out_turn, 0);
    chk({nm, "_first"}, bus.out_first, 0);
    chk({nm, "_last"},  bus.out_last, 0);
    chk({nm, "_err"},   bus.err, 0);
    chk({nm, "_ready"}, bus.req_ready, 1);
  endtask

  task automatic accept_now();
    bus.req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (accepted) break;
    end
    chk("accept_seen", accepted, 1);
  endtask

  initial begin
    //          base   mreg  moff    st     mode   sew   rdy beats errs
    vecs[0] = '{5'd4,  3'd1, 8'd2,   8'd0,   2'd0, 2'd0, 0, 6,    0};
    vecs[1] = '{5'd4,  3'd1, 8'd2,   8'd2,   2'd0, 2'd0, 1, 4,    0};
    vecs[2] = '{5'd8,  3'd0, 8'd1,   8'd0,   2'd1, 2'd0, 0, WB,   0};
    vecs[3] = '{5'd30, 3'd0, 8'd0,   8'd0,   2'd2, 2'd2, 0, 1024, 0};
    vecs[4] = '{5'd0,  3'd0, 8'd3,   8'd5,   2'd0, 2'd0, 0, 0,    1};
    vecs[5] = '{5'd3,  3'd0, 8'd7,   8'd7,   2'd0, 2'd0, 0, 1,    0};
    vecs[6] = '{5'd31, 3'd2, 8'd1,   8'd1,   2'd3, 2'd0, 2, 5,    0};
    vecs[7] = '{5'd10, 3'd1, 8'd0,   8'd0,   2'd1, 2'd0, 2, WB,   0};
    vecs[8] = '{5'd5,  3'd0, 8'd0,   8'd250, 2'd2, 2'd0, 1, 6,    0};

    rst_n = 1'b0;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.out_ready = 1'b0;
    set_req('0, '0, '0, '0, '0, '0);
    err_due = 1'b0; prev_stall = 1'b0; nbeats = 0; nerrs = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Chaining: B held valid while A streams; no bubble between them.
    bus.out_ready = 1'b1; nbeats = 0;
    set_req(5'd4, 3'd1, 8'd2, 8'd0, 2'd0, 2'd0);
    accept_now();
    set_req(5'd12, 3'd0, 8'd1, 8'd0, 2'd0, 2'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      if (accepted) bus.req_valid = 1'b0;
    end
    chk("chain_drain", sb.size(), 0);
    chk("chain_beats", nbeats, 8);

    // Flush mid-sequence while another request waits; it lands after the flush.
    nbeats = 0;
    set_req(5'd4, 3'd1, 8'd2, 8'd0, 2'd0, 2'd0);
    accept_now();
    bus.req_valid = 1'b0;
    step(); step();
    set_req(5'd20, 3'd0, 8'd0, 8'd0, 2'd0, 2'd0);
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step(); step();
    chk("flush_drain", sb.size(), 0);
    chk("flush_beats", nbeats, 3);

    // Reset in RUN clears every output.
    set_req(5'd4, 3'd1, 8'd2, 8'd0, 2'd0, 2'd0);
    accept_now();
    bus.req_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
